// File: rtl/strobe_decoder_pkg.sv
// Shared definitions for the strobe decoder: run-time mode encoding.
package strobe_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_PULSE = 2'd1,
    MODE_LATCH = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational address-to-one-hot decoder with an active-high enable.
module onehot_decoder #(
  parameter int A_WIDTH = 4
) (
  input  logic [A_WIDTH-1:0]      addr_i,
  input  logic                    en_i,
  output logic [(2**A_WIDTH)-1:0] onehot_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**A_WIDTH; gi++) begin : g_bit
      assign onehot_o[gi] = en_i && (addr_i == A_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/strobe_decoder.sv
// Registered active-low select decoder with LEVEL, one-shot PULSE and LATCH modes.
// All outputs come straight from flops so strobes are glitch-free.
module strobe_decoder
  import strobe_decoder_pkg::*;
#(
  parameter int A_WIDTH   = 4,
  parameter int G_WIDTH   = 2,
  parameter int PULSE_LEN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [A_WIDTH-1:0]      a,
  input  logic [G_WIDTH-1:0]      g_n,
  input  logic [1:0]              mode,
  input  logic                    clr,
  output logic [(2**A_WIDTH)-1:0] y_n,
  output logic                    busy
);

  localparam int N     = 2**A_WIDTH;
  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN);

  logic               en_q;
  logic [1:0]         mode_q;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_q, hold_d;
  logic [N-1:0]       y_n_q, y_n_d;
  logic               busy_q, busy_d;

  logic         en, rise, mode_chg, use_level, strobe_on;
  logic [N-1:0] level_hot, strobe_hot;

  assign en       = (g_n == '0);
  assign rise     = en && !en_q;
  assign mode_chg = (mode != mode_q);

  onehot_decoder #(.A_WIDTH(A_WIDTH)) u_level_dec (
    .addr_i   (a),
    .en_i     (en),
    .onehot_o (level_hot)
  );

  // Decoding the next-state address lets a LATCH re-target move without a gap.
  onehot_decoder #(.A_WIDTH(A_WIDTH)) u_strobe_dec (
    .addr_i   (addr_d),
    .en_i     (strobe_on),
    .onehot_o (strobe_hot)
  );

  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    use_level = 1'b0;
    if (mode_chg) begin
      cnt_d  = '0;
      hold_d = 1'b0;
    end else begin
      case (mode_e'(mode))
        MODE_LEVEL: use_level = 1'b1;
        MODE_PULSE: begin
          if (clr) begin
            cnt_d = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (rise) begin
            addr_d = a;
            cnt_d  = PULSE_LOAD;
          end
        end
        MODE_LATCH: begin
          if (clr) begin
            hold_d = 1'b0;
          end else if (rise) begin
            addr_d = a;
            hold_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign strobe_on = (cnt_d != '0) || hold_d;
  assign y_n_d     = use_level ? ~level_hot : ~strobe_hot;
  assign busy_d    = strobe_on;

  // en_q resets high so an enable held across reset release is not a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b1;
      mode_q <= 2'd0;
      addr_q <= '0;
      cnt_q  <= '0;
      hold_q <= 1'b0;
      y_n_q  <= '1;
      busy_q <= 1'b0;
    end else begin
      en_q   <= en;
      mode_q <= mode;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      y_n_q  <= y_n_d;
      busy_q <= busy_d;
    end
  end

  assign y_n  = y_n_q;
  assign busy = busy_q;

endmodule
